// File: rtl/multicycle_control_unit.sv
// Control FSM for a multi-cycle RV32I datapath: sequences fetch/decode/execute/memory/writeback,
// drives datapath mux selects and write enables, and guards the memory handshake with a watchdog.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic             addr_src_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             reg_write_o,
  output logic [2:0]       imm_sel_o,
  output logic [1:0]       alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic [1:0]       result_src_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             illegal_o,
  output logic             bus_err_o
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC_R, EXEC_I, LUI, ALU_WB, MEM_ADDR,
    MEM_READ, MEM_WB, MEM_WRITE, BRANCH, JAL, JALR, JALR_PC, TRAP
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              timeout;

  function automatic logic [2:0] imm_fmt(input logic [6:0] op);
    case (op)
      OP_IMM, OP_JALR, OP_LOAD: imm_fmt = 3'd1;
      OP_STORE:                 imm_fmt = 3'd2;
      OP_BR:                    imm_fmt = 3'd3;
      OP_LUI:                   imm_fmt = 3'd4;
      OP_JAL:                   imm_fmt = 3'd5;
      default:                  imm_fmt = 3'd0;
    endcase
  endfunction

  // A waiting state that sees ready in its last permitted cycle still completes normally.
  assign timeout = (wait_q == WAIT_LAST) && !mem_ready_i;

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    instret_d    = instret_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    addr_src_o   = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    reg_write_o  = 1'b0;
    imm_sel_o    = 3'd0;
    alu_src_a_o  = 2'd0;
    alu_src_b_o  = 2'd0;
    alu_op_o     = 2'd0;
    result_src_o = 2'd0;
    retire_o     = 1'b0;

    if (state_q != IDLE && state_q != FETCH && state_q != TRAP) imm_sel_o = imm_fmt(op_i);

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'd2;
        result_src_o = 2'd2;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = DECODE;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DECODE: begin
        alu_src_a_o = 2'd1;
        alu_src_b_o = 2'd1;
        case (op_i)
          OP_R:             state_d = EXEC_R;
          OP_IMM:           state_d = EXEC_I;
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_BR:            state_d = BRANCH;
          OP_JAL:           state_d = JAL;
          OP_JALR:          state_d = JALR;
          OP_LUI:           state_d = LUI;
          default: begin
            illegal_d = 1'b1;
            state_d   = TRAP;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a_o = 2'd2;
        alu_op_o    = 2'd2;
        state_d     = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a_o = 2'd2;
        alu_src_b_o = 2'd1;
        alu_op_o    = 2'd2;
        state_d     = ALU_WB;
      end
      LUI: begin
        alu_src_a_o = 2'd3;
        alu_src_b_o = 2'd1;
        state_d     = ALU_WB;
      end
      ALU_WB: begin
        reg_write_o = 1'b1;
        retire_o    = 1'b1;
        instret_d   = instret_q + 1'b1;
        state_d     = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a_o = 2'd2;
        alu_src_b_o = 2'd1;
        state_d     = (op_i == OP_LOAD) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_req_o  = 1'b1;
        addr_src_o = 1'b1;
        if (mem_ready_i) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = 2'd1;
        retire_o     = 1'b1;
        instret_d    = instret_q + 1'b1;
        state_d      = FETCH;
      end
      MEM_WRITE: begin
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        addr_src_o  = 1'b1;
        if (mem_ready_i) begin
          retire_o  = 1'b1;
          instret_d = instret_q + 1'b1;
          state_d   = FETCH;
        end else if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = TRAP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      BRANCH: begin
        alu_src_a_o = 2'd2;
        alu_op_o    = 2'd1;
        pc_write_o  = branch_taken_i;
        retire_o    = 1'b1;
        instret_d   = instret_q + 1'b1;
        state_d     = FETCH;
      end
      JAL: begin
        pc_write_o  = 1'b1;
        alu_src_a_o = 2'd1;
        alu_src_b_o = 2'd2;
        state_d     = ALU_WB;
      end
      JALR: begin
        alu_src_a_o = 2'd2;
        alu_src_b_o = 2'd1;
        state_d     = JALR_PC;
      end
      JALR_PC: begin
        pc_write_o  = 1'b1;
        alu_src_a_o = 2'd1;
        alu_src_b_o = 2'd2;
        state_d     = ALU_WB;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign instret_o = instret_q;
  assign illegal_o = illegal_q;
  assign bus_err_o = bus_err_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: expected control vectors are queued per cycle
// and compared against the DUT at the falling edge.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op_i;
  logic        branch_taken_i;
  logic        mem_ready_i;
  logic        mem_req_o, mem_write_o, addr_src_o, ir_write_o, pc_write_o, reg_write_o, retire_o;
  logic [2:0]  imm_sel_o;
  logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o, result_src_o;
  logic [31:0] instret_o;
  logic        illegal_o, bus_err_o;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .op_i(op_i), .branch_taken_i(branch_taken_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
    .addr_src_o(addr_src_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .reg_write_o(reg_write_o), .imm_sel_o(imm_sel_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .result_src_o(result_src_o),
    .retire_o(retire_o), .instret_o(instret_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o)
  );

  // stb = {mem_req, mem_write, addr_src, ir_write, pc_write, reg_write, retire}
  typedef struct packed {
    logic [6:0]  stb;
    logic [2:0]  imm;
    logic [1:0]  a, b, aop, rs;
    logic        ill, berr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;
  logic        exp_ill = 1'b0;
  logic        exp_berr = 1'b0;

  function automatic exp_t observed();
    exp_t o;
    o.stb  = {mem_req_o, mem_write_o, addr_src_o, ir_write_o, pc_write_o, reg_write_o, retire_o};
    o.imm  = imm_sel_o;
    o.a    = alu_src_a_o;
    o.b    = alu_src_b_o;
    o.aop  = alu_op_o;
    o.rs   = result_src_o;
    o.ill  = illegal_o;
    o.berr = bus_err_o;
    o.cnt  = instret_o;
    return o;
  endfunction

  task automatic push(input logic [6:0] stb, input logic [2:0] imm,
                      input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] aop, input logic [1:0] rs);
    exp_t e;
    e.stb = stb; e.imm = imm; e.a = a; e.b = b; e.aop = aop; e.rs = rs;
    e.ill = exp_ill; e.berr = exp_berr; e.cnt = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic check_out(input string tag);
    exp_t e, o;
    checks++;
    assert (sb_q.size() != 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      o = observed();
      assert (o[51:32] === e[51:32]) else begin
        errors++;
        $error("FAIL %s ctl got=%h exp=%h", tag, o[51:32], e[51:32]);
      end
      checks++;
      assert (o.cnt === e.cnt) else begin
        errors++;
        $error("FAIL %s instret got=%0d exp=%0d", tag, o.cnt, e.cnt);
      end
      if (e.stb[0]) exp_cnt = exp_cnt + 1;
    end
  endtask

  task automatic cyc(input string tag, input logic [6:0] op, input logic rdy, input logic tk,
                     input logic [6:0] stb, input logic [2:0] imm, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] aop, input logic [1:0] rs);
    op_i = op; mem_ready_i = rdy; branch_taken_i = tk;
    push(stb, imm, a, b, aop, rs);
    @(negedge clk);
    check_out(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [6:0] op);
    cyc("fetch", op, 1'b1, 1'b0, 7'b1001100, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear without waiting for a clock.
  task automatic areset(input string tag);
    reset = 1'b0;
    exp_cnt = '0; exp_ill = 1'b0; exp_berr = 1'b0;
    push(7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    #2;
    check_out(tag);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; op_i = 7'h33; mem_ready_i = 1'b1; branch_taken_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    #2;
    check_out("reset");
    reset = 1'b1;
    cyc("idle", 7'h33, 1'b1, 1'b0, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

    // ADD
    fetch(7'h33);
    cyc("add_dec", 7'h33, 1'b1, 1'b0, 7'b0000000, 3'd0, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("add_ex",  7'h33, 1'b1, 1'b0, 7'b0000000, 3'd0, 2'd2, 2'd0, 2'd2, 2'd0);
    cyc("add_wb",  7'h33, 1'b1, 1'b0, 7'b0000011, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

    // LW with ready arriving in the last permitted wait cycle of both FETCH and MEM_READ
    for (int i = 0; i < 3; i++)
      cyc("lw_fwait", 7'h03, 1'b0, 1'b0, 7'b1000000, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2);
    fetch(7'h03);
    cyc("lw_dec",  7'h03, 1'b1, 1'b0, 7'b0000000, 3'd1, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("lw_addr", 7'h03, 1'b1, 1'b0, 7'b0000000, 3'd1, 2'd2, 2'd1, 2'd0, 2'd0);
    for (int i = 0; i < 3; i++)
      cyc("lw_rwait", 7'h03, 1'b0, 1'b0, 7'b1010000, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
    cyc("lw_read", 7'h03, 1'b1, 1'b0, 7'b1010000, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
    cyc("lw_wb",   7'h03, 1'b1, 1'b0, 7'b0000011, 3'd1, 2'd0, 2'd0, 2'd0, 2'd1);

    // BEQ not taken, then taken
    fetch(7'h63);
    cyc("beq_dec", 7'h63, 1'b1, 1'b0, 7'b0000000, 3'd3, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("beq_nt",  7'h63, 1'b1, 1'b0, 7'b0000001, 3'd3, 2'd2, 2'd0, 2'd1, 2'd0);
    fetch(7'h63);
    cyc("beq_dec", 7'h63, 1'b1, 1'b1, 7'b0000000, 3'd3, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("beq_tk",  7'h63, 1'b1, 1'b1, 7'b0000101, 3'd3, 2'd2, 2'd0, 2'd1, 2'd0);

    // JALR
    fetch(7'h67);
    cyc("jalr_dec", 7'h67, 1'b1, 1'b0, 7'b0000000, 3'd1, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("jalr_ex",  7'h67, 1'b1, 1'b0, 7'b0000000, 3'd1, 2'd2, 2'd1, 2'd0, 2'd0);
    cyc("jalr_pc",  7'h67, 1'b1, 1'b0, 7'b0000100, 3'd1, 2'd1, 2'd2, 2'd0, 2'd0);
    cyc("jalr_wb",  7'h67, 1'b1, 1'b0, 7'b0000011, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);

    // ADDI, LUI, JAL
    fetch(7'h13);
    cyc("addi_dec", 7'h13, 1'b1, 1'b0, 7'b0000000, 3'd1, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("addi_ex",  7'h13, 1'b1, 1'b0, 7'b0000000, 3'd1, 2'd2, 2'd1, 2'd2, 2'd0);
    cyc("addi_wb",  7'h13, 1'b1, 1'b0, 7'b0000011, 3'd1, 2'd0, 2'd0, 2'd0, 2'd0);
    fetch(7'h37);
    cyc("lui_dec", 7'h37, 1'b1, 1'b0, 7'b0000000, 3'd4, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("lui_ex",  7'h37, 1'b1, 1'b0, 7'b0000000, 3'd4, 2'd3, 2'd1, 2'd0, 2'd0);
    cyc("lui_wb",  7'h37, 1'b1, 1'b0, 7'b0000011, 3'd4, 2'd0, 2'd0, 2'd0, 2'd0);
    fetch(7'h6F);
    cyc("jal_dec", 7'h6F, 1'b1, 1'b0, 7'b0000000, 3'd5, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("jal_ex",  7'h6F, 1'b1, 1'b0, 7'b0000100, 3'd5, 2'd1, 2'd2, 2'd0, 2'd0);
    cyc("jal_wb",  7'h6F, 1'b1, 1'b0, 7'b0000011, 3'd5, 2'd0, 2'd0, 2'd0, 2'd0);

    // SW completing, then a second SW interrupted by reset while waiting
    fetch(7'h23);
    cyc("sw_dec",  7'h23, 1'b1, 1'b0, 7'b0000000, 3'd2, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("sw_addr", 7'h23, 1'b1, 1'b0, 7'b0000000, 3'd2, 2'd2, 2'd1, 2'd0, 2'd0);
    cyc("sw_wr",   7'h23, 1'b1, 1'b0, 7'b1110001, 3'd2, 2'd0, 2'd0, 2'd0, 2'd0);
    fetch(7'h23);
    cyc("sw_dec",  7'h23, 1'b0, 1'b0, 7'b0000000, 3'd2, 2'd1, 2'd1, 2'd0, 2'd0);
    cyc("sw_addr", 7'h23, 1'b0, 1'b0, 7'b0000000, 3'd2, 2'd2, 2'd1, 2'd0, 2'd0);
    cyc("sw_wait", 7'h23, 1'b0, 1'b0, 7'b1110000, 3'd2, 2'd0, 2'd0, 2'd0, 2'd0);
    areset("rst_mid_sw");
    cyc("idle2", 7'h33, 1'b1, 1'b0, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    fetch(7'h7F);

    // Illegal opcode
    cyc("ill_dec", 7'h7F, 1'b1, 1'b0, 7'b0000000, 3'd0, 2'd1, 2'd1, 2'd0, 2'd0);
    exp_ill = 1'b1;
    cyc("ill_trap",  7'h7F, 1'b1, 1'b0, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    cyc("ill_stick", 7'h13, 1'b1, 1'b0, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

    // Memory timeout in FETCH
    areset("rst_trap");
    cyc("idle3", 7'h33, 1'b0, 1'b0, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < 4; i++)
      cyc("to_fwait", 7'h33, 1'b0, 1'b0, 7'b1000000, 3'd0, 2'd0, 2'd2, 2'd0, 2'd2);
    exp_berr = 1'b1;
    cyc("to_trap",  7'h33, 1'b0, 1'b0, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);
    cyc("to_stick", 7'h33, 1'b1, 1'b0, 7'b0, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
